cc_stream_decryptor: RTL and testbench

//  Command-centre side decryptor for the drone uplink cipher: takes a 64-bit ciphertext plus the
//  8-bit shared key from the DH exchange, recovers the plaintext one byte per enabled cycle.

---
 rtl/cc_stream_decryptor.sv | 118 +++++++++++
 tb/tb_cc_stream_decryptor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cc_stream_decryptor.sv
// Command-centre uplink decryptor: undoes the chained LFSR-keystream cipher one byte per
// enabled cycle and returns the 64-bit plaintext through a valid/ready handshake.
module cc_stream_decryptor #(
    parameter logic [7:0] IV        = 8'h00,
    parameter logic [7:0] ZERO_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        key_load,
    input  logic [7:0]  key,
    output logic        key_err,
    input  logic        c_valid,
    output logic        c_ready,
    input  logic [63:0] c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] decrypted,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    // Handshakes: a transfer happens on an enabled rising edge where valid and ready are both
    // high; the source holds its data and valid until that edge, and ready never depends on valid.
    typedef enum logic [1:0] {
        NOKEY  = 2'd0,
        READY  = 2'd1,
        DECODE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    logic [7:0]  key_reg;
    logic [63:0] c_reg;
    logic [7:0]  ks;
    logic [7:0]  prev;
    logic [2:0]  idx;

    logic [7:0]  cur_byte;
    logic [7:0]  plain_byte;
    logic [7:0]  ks_next;
    logic [7:0]  eff_key;
    logic [7:0]  seed;

    always_comb begin
        cur_byte   = c_reg[{idx, 3'b000} +: 8];
        plain_byte = (cur_byte - prev) ^ ks;
        ks_next    = {ks[6:0], ks[7] ^ ks[5] ^ ks[4] ^ ks[3]};
        // A key loaded on the same edge as the ciphertext already governs that ciphertext.
        eff_key    = key_load ? key : key_reg;
        seed       = (eff_key == 8'h00) ? ZERO_SEED : eff_key;
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= NOKEY;
            key_reg   <= 8'h00;
            c_reg     <= 64'h0;
            ks        <= 8'h00;
            prev      <= 8'h00;
            idx       <= 3'd0;
            decrypted <= 64'h0;
            c_ready   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            key_err   <= 1'b0;
        end else if (ena) begin
            key_err <= 1'b0;
            case (state)
                NOKEY: begin
                    if (key_load) begin
                        key_reg <= key;
                        c_ready <= 1'b1;
                        state   <= READY;
                    end
                end
                READY: begin
                    if (key_load) begin
                        key_reg <= key;
                    end
                    if (c_valid) begin
                        c_reg   <= c;
                        ks      <= seed;
                        prev    <= IV;
                        idx     <= 3'd0;
                        c_ready <= 1'b0;
                        busy    <= 1'b1;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    key_err                         <= key_load;
                    decrypted[{idx, 3'b000} +: 8] <= plain_byte;
                    ks                              <= ks_next;
                    prev                            <= cur_byte;
                    idx                             <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    key_err <= key_load;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        c_ready   <= 1'b1;
                        state     <= READY;
                    end
                end
                default: state <= NOKEY;
            endcase
        end
    end

endmodule

// File: tb/tb_cc_stream_decryptor.sv
// Directed bench for cc_stream_decryptor: hand-computed vectors, reset/enable/handshake corner
// cases and a round-trip against a small encoder model.
module tb_cc_stream_decryptor;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        key_load;
    logic [7:0]  key;
    logic        key_err;
    logic        c_valid;
    logic        c_ready;
    logic [63:0] c;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] decrypted;
    logic        busy;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    cc_stream_decryptor dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .key_load  (key_load),
        .key       (key),
        .key_err   (key_err),
        .c_valid   (c_valid),
        .c_ready   (c_ready),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .decrypted (decrypted),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // encoder model
    function automatic logic [63:0] encrypt(input logic [7:0] k, input logic [63:0] m);
        logic [7:0]  ks;
        logic [7:0]  pc;
        logic [63:0] r;
        ks = (k == 8'h00) ? 8'hA5 : k;
        pc = 8'h00;
        r  = 64'h0;
        for (int i = 0; i < 8; i++) begin
            pc = (m[8*i +: 8] ^ ks) + pc;
            r[8*i +: 8] = pc;
            ks = {ks[6:0], ks[7] ^ ks[5] ^ ks[4] ^ ks[3]};
        end
        return r;
    endfunction

    // driver tasks
    task automatic load_key(input logic [7:0] k);
        key      = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
    endtask

    task automatic send_c(input logic [63:0] v);
        int n;
        n = 0;
        while (c_ready !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check("c_ready_wait", c_ready, 1'b1);
        c       = v;
        c_valid = 1'b1;
        step();
        c_valid = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 40) begin
            step();
            edges++;
        end
        check("out_valid_wait", out_valid, 1'b1);
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic run_job(input string tag, input logic [63:0] cv, input logic [63:0] exp);
        int lat;
        send_c(cv);
        wait_valid(lat);
        check({tag, "_lat"}, lat, 8);
        check({tag, "_data"}, decrypted, exp);
        take_out();
    endtask

    initial begin
        int lat;
        logic [7:0]  rk;
        logic [63:0] rm;

        rst       = 1'b0;
        ena       = 1'b1;
        key_load  = 1'b0;
        key       = 8'h00;
        c_valid   = 1'b0;
        c         = 64'h0;
        out_ready = 1'b0;
        #12;
        check("rst_state", state_dbg, 2'd0);
        check("rst_outs", {c_ready, out_valid, busy, key_err}, 4'b0000);
        check("rst_dec", decrypted, 64'h0);
        rst = 1'b1;
        step();

        // key 01, zero plaintext and wrap-around subtraction vectors
        load_key(8'h01);
        check("ready_state", state_dbg, 2'd1);
        check("ready_c_ready", c_ready, 1'b1);
        run_job("vec_zero_msg", 64'h188A_4320_0F07_0301, 64'h0);
        check("after_take_ready", c_ready, 1'b1);
        check("after_take_valid", out_valid, 1'b0);
        run_job("vec_zero_ct", 64'h0, 64'h8E47_2311_0804_0201);

        // reset mid-DECODE after three bytes
        send_c(64'h0);
        check("dec_busy", busy, 1'b1);
        step(); step(); step();
        check("partial_dec", decrypted[23:0], 24'h040201);
        rst = 1'b0;
        #1;
        check("midrst_outs", {c_ready, out_valid, busy, key_err}, 4'b0000);
        check("midrst_dec", decrypted, 64'h0);
        check("midrst_state", state_dbg, 2'd0);
        #3;
        rst     = 1'b1;
        c       = 64'h1234;
        c_valid = 1'b1;
        step(); step(); step();
        c_valid = 1'b0;
        check("nokey_ignore_c", {c_ready, busy, out_valid}, 3'b000);
        check("nokey_state", state_dbg, 2'd0);

        // ena toggled every other cycle while decoding
        load_key(8'h01);
        send_c(64'h188A_4320_0F07_0301);
        lat = 0;
        for (int i = 0; i < 40 && out_valid !== 1'b1; i++) begin
            ena = (i % 2 == 0) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (ena) lat++;
            if (!ena) check("ena_hold_busy", busy, 1'b1);
        end
        ena = 1'b1;
        check("ena_lat", lat, 8);
        check("ena_data", decrypted, 64'h0);
        ena = 1'b0;
        out_ready = 1'b1;
        step(); step();
        check("ena_freeze_out", out_valid, 1'b1);
        ena = 1'b1;
        step();
        out_ready = 1'b0;
        check("ena_release_out", out_valid, 1'b0);

        // key_load rejected while busy; output held while consumer stalls
        send_c(64'h188A_4320_0F07_0301);
        step();
        key      = 8'h55;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        check("key_err_pulse", key_err, 1'b1);
        step();
        check("key_err_clear", key_err, 1'b0);
        wait_valid(lat);
        check("rekey_old_key", decrypted, 64'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_hold", {out_valid, c_ready, busy}, 3'b101);
            check("stall_data", decrypted, 64'h0);
        end
        take_out();
        run_job("key_retained", 64'h0, 64'h8E47_2311_0804_0201);

        // key and ciphertext on the same edge: new key governs
        key      = 8'h02;
        key_load = 1'b1;
        c        = encrypt(8'h02, 64'hDEAD_BEEF_0123_4567);
        c_valid  = 1'b1;
        step();
        key_load = 1'b0;
        c_valid  = 1'b0;
        wait_valid(lat);
        check("same_edge_lat", lat, 8);
        check("same_edge_data", decrypted, 64'hDEAD_BEEF_0123_4567);
        take_out();

        // zero-key seed then random round trips
        load_key(8'h00);
        run_job("zero_key", encrypt(8'h00, 64'h0011_2233_4455_6677), 64'h0011_2233_4455_6677);
        for (int i = 0; i < 200; i++) begin
            rk = (i % 4 == 0) ? 8'h00 : 8'($urandom_range(255, 0));
            rm = {32'($urandom), 32'($urandom)};
            load_key(rk);
            send_c(encrypt(rk, rm));
            wait_valid(lat);
            check("rand_trip", decrypted, rm);
            take_out();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
